// File: rtl/branch_predictor.sv
// branch_predictor
// Tagged, direct-mapped table of 2-bit saturating counters. A branch in FD
// gets a combinational taken/not-taken guess, and the table is trained when
// that branch resolves in X. Two wrapping 32-bit performance counters track
// lookups and mispredictions.
module branch_predictor #(
    parameter  int PC_WIDTH = 32,
    parameter  int LINES    = 16,
    localparam int IDX_W    = $clog2(LINES),
    localparam int TAG_W    = PC_WIDTH - IDX_W - 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PC_WIDTH-1:0] pc_guess,
    input  logic                is_br_guess,
    output logic                pred_taken,
    input  logic [PC_WIDTH-1:0] pc_check,
    input  logic                is_br_check,
    input  logic                br_taken_check,
    input  logic                mispredict,
    output logic [31:0]         lookup_cnt,
    output logic [31:0]         mispred_cnt
);

    // Counter encodings: the MSB is the taken guess.
    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    // Table storage. Only the valid bits are reset; tag and counter contents
    // are meaningless until their line has been allocated.
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [LINES];
    logic [1:0]       ctr_q [LINES];

    logic [31:0] lookup_q;
    logic [31:0] mispred_q;

    // PC fields. Bits [1:0] are word-alignment bits and carry no information.
    logic [IDX_W-1:0] idx_guess;
    logic [TAG_W-1:0] tag_guess;
    logic [IDX_W-1:0] idx_check;
    logic [TAG_W-1:0] tag_check;
    logic [3:0]       unused_pc_low;

    assign idx_guess     = pc_guess[IDX_W+1:2];
    assign tag_guess     = pc_guess[PC_WIDTH-1:IDX_W+2];
    assign idx_check     = pc_check[IDX_W+1:2];
    assign tag_check     = pc_check[PC_WIDTH-1:IDX_W+2];
    assign unused_pc_low = {pc_guess[1:0], pc_check[1:0]};

    // Lookup path: a tag hit on a valid line predicts from the counter MSB.
    // This reads the pre-edge table, so a same-cycle update is not bypassed.
    logic hit_guess;

    always_comb begin
        hit_guess  = valid_q[idx_guess] && (tag_q[idx_guess] == tag_guess);
        pred_taken = is_br_guess && hit_guess && ctr_q[idx_guess][1];
    end

    // Training path: on a hit the counter moves toward the outcome and
    // saturates; on a miss the line is (re)allocated in the weak state that
    // matches the outcome.
    logic       hit_check;
    logic [1:0] ctr_cur;
    logic [1:0] ctr_next;

    always_comb begin
        hit_check = valid_q[idx_check] && (tag_q[idx_check] == tag_check);
        ctr_cur   = ctr_q[idx_check];
        ctr_next  = ctr_cur;
        if (!hit_check) begin
            ctr_next = br_taken_check ? CTR_WEAK_T : CTR_WEAK_NT;
        end else if (br_taken_check) begin
            ctr_next = (ctr_cur == CTR_STRONG_T) ? CTR_STRONG_T : ctr_cur + 2'd1;
        end else begin
            ctr_next = (ctr_cur == CTR_STRONG_NT) ? CTR_STRONG_NT : ctr_cur - 2'd1;
        end
    end

    // Valid bits: cleared by reset, set when a resolving branch allocates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (is_br_check) begin
            valid_q[idx_check] <= 1'b1;
        end
    end

    // Tag and counter storage: written on every resolving branch. A write on
    // a reset edge is harmless because the valid bit stays cleared.
    always_ff @(posedge clk) begin
        if (is_br_check) begin
            tag_q[idx_check] <= tag_check;
            ctr_q[idx_check] <= ctr_next;
        end
    end

    // Lookup performance counter, wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_q <= '0;
        end else if (is_br_guess) begin
            lookup_q <= lookup_q + 32'd1;
        end
    end

    // Mispredict counter; mispredict is only meaningful alongside is_br_check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispred_q <= '0;
        end else if (is_br_check && mispredict) begin
            mispred_q <= mispred_q + 32'd1;
        end
    end

    assign lookup_cnt  = lookup_q;
    assign mispred_cnt = mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
// Directed, table-driven bench for branch_predictor with hand-written
// sequences for counter wrap and asynchronous reset.
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_guess;
    logic        is_br_guess;
    logic        pred_taken;
    logic [31:0] pc_check;
    logic        is_br_check;
    logic        br_taken_check;
    logic        mispredict;
    logic [31:0] lookup_cnt;
    logic [31:0] mispred_cnt;

    int errors = 0;
    int checks = 0;

    branch_predictor #(.PC_WIDTH(32), .LINES(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_guess       (pc_guess),
        .is_br_guess    (is_br_guess),
        .pred_taken     (pred_taken),
        .pc_check       (pc_check),
        .is_br_check    (is_br_check),
        .br_taken_check (br_taken_check),
        .mispredict     (mispredict),
        .lookup_cnt     (lookup_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus plus the values expected just before its edge.
    // Counter expectations reflect all earlier cycles.
    typedef struct {
        logic        gv;
        logic [31:0] gpc;
        logic        cv;
        logic [31:0] cpc;
        logic        tk;
        logic        mp;
        logic        ep;
        logic [31:0] el;
        logic [31:0] em;
    } vec_t;

    vec_t vecs[$];

    task automatic applyStimulus(input logic gv, input logic [31:0] gpc,
                                 input logic cv, input logic [31:0] cpc,
                                 input logic tk, input logic mp);
        is_br_guess    = gv;
        pc_guess       = gpc;
        is_br_check    = cv;
        pc_check       = cpc;
        br_taken_check = tk;
        mispredict     = mp;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        // gv gpc          cv cpc          tk mp  ep el     em
        vecs.push_back('{1, 32'h1000, 0, 32'h0,    0, 0, 0, 32'd0,  32'd0}); // v0 cold miss
        vecs.push_back('{0, 32'h0,    1, 32'h1000, 1, 0, 0, 32'd1,  32'd0}); // v1 alloc 10
        vecs.push_back('{1, 32'h1000, 0, 32'h0,    0, 0, 1, 32'd1,  32'd0}); // v2
        vecs.push_back('{1, 32'h1000, 1, 32'h1000, 1, 0, 1, 32'd2,  32'd0}); // v3 ->11
        vecs.push_back('{1, 32'h1000, 1, 32'h1000, 1, 0, 1, 32'd3,  32'd0}); // v4 sat 11
        vecs.push_back('{1, 32'h1000, 1, 32'h1000, 0, 0, 1, 32'd4,  32'd0}); // v5 ->10
        vecs.push_back('{1, 32'h1000, 0, 32'h0,    0, 0, 1, 32'd5,  32'd0}); // v6
        vecs.push_back('{0, 32'h0,    1, 32'h1000, 0, 0, 0, 32'd6,  32'd0}); // v7 ->01
        vecs.push_back('{1, 32'h1000, 0, 32'h0,    0, 0, 0, 32'd6,  32'd0}); // v8
        vecs.push_back('{0, 32'h0,    1, 32'h1000, 0, 0, 0, 32'd7,  32'd0}); // v9 ->00
        vecs.push_back('{0, 32'h0,    1, 32'h1000, 0, 0, 0, 32'd7,  32'd0}); // v10 sat 00
        vecs.push_back('{0, 32'h0,    1, 32'h1000, 1, 0, 0, 32'd7,  32'd0}); // v11 ->01
        vecs.push_back('{1, 32'h1000, 0, 32'h0,    0, 0, 0, 32'd7,  32'd0}); // v12
        vecs.push_back('{0, 32'h0,    1, 32'h1000, 1, 0, 0, 32'd8,  32'd0}); // v13 ->10
        vecs.push_back('{0, 32'h0,    1, 32'h1000, 1, 0, 0, 32'd8,  32'd0}); // v14 ->11
        vecs.push_back('{1, 32'h1000, 1, 32'h1040, 0, 0, 1, 32'd8,  32'd0}); // v15 alias
        vecs.push_back('{1, 32'h1040, 0, 32'h0,    0, 0, 0, 32'd9,  32'd0}); // v16 ctr 01
        vecs.push_back('{1, 32'h1000, 0, 32'h0,    0, 0, 0, 32'd10, 32'd0}); // v17 miss
        vecs.push_back('{0, 32'h0,    1, 32'h1040, 1, 0, 0, 32'd11, 32'd0}); // v18 ->10
        vecs.push_back('{1, 32'h1040, 0, 32'h0,    0, 0, 1, 32'd11, 32'd0}); // v19
        vecs.push_back('{0, 32'h0,    1, 32'h2000, 0, 0, 0, 32'd12, 32'd0}); // v20 alloc 01
        vecs.push_back('{1, 32'h2000, 1, 32'h2000, 1, 0, 0, 32'd12, 32'd0}); // v21 hazard
        vecs.push_back('{1, 32'h2000, 0, 32'h0,    0, 0, 1, 32'd13, 32'd0}); // v22
        vecs.push_back('{0, 32'h0,    1, 32'h1004, 1, 0, 0, 32'd14, 32'd0}); // v23 idx1
        vecs.push_back('{1, 32'h1004, 0, 32'h0,    0, 0, 1, 32'd14, 32'd0}); // v24
        vecs.push_back('{1, 32'h2000, 0, 32'h0,    0, 0, 1, 32'd15, 32'd0}); // v25
        vecs.push_back('{1, 32'h2003, 0, 32'h0,    0, 0, 1, 32'd16, 32'd0}); // v26 low bits
        vecs.push_back('{0, 32'h0,    0, 32'h1004, 0, 1, 0, 32'd17, 32'd0}); // v27 no check
        vecs.push_back('{1, 32'h1004, 0, 32'h0,    0, 0, 1, 32'd17, 32'd0}); // v28 unchanged
        vecs.push_back('{0, 32'h0,    1, 32'h1004, 1, 1, 0, 32'd18, 32'd0}); // v29 mp
        vecs.push_back('{0, 32'h0,    1, 32'h1004, 1, 1, 0, 32'd18, 32'd1}); // v30 mp
        vecs.push_back('{0, 32'h0,    1, 32'h1004, 0, 1, 0, 32'd18, 32'd2}); // v31 mp
        vecs.push_back('{1, 32'h1004, 0, 32'h0,    0, 0, 1, 32'd18, 32'd3}); // v32
        vecs.push_back('{0, 32'h1004, 0, 32'h0,    0, 0, 0, 32'd19, 32'd3}); // v33 no guess

        rst_n = 1'b0;
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 0);
        repeat (2) @(negedge clk);
        applyStimulus(1, 32'h1000, 0, 32'h0, 0, 0);
        #1;
        checkOutput("reset pred", {31'd0, pred_taken}, 32'd0);
        checkOutput("reset lookup", lookup_cnt, 32'd0);
        checkOutput("reset mispred", mispred_cnt, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i].gv, vecs[i].gpc, vecs[i].cv, vecs[i].cpc,
                          vecs[i].tk, vecs[i].mp);
            #1;
            checkOutput($sformatf("v%0d pred", i), {31'd0, pred_taken}, {31'd0, vecs[i].ep});
            checkOutput($sformatf("v%0d lookup", i), lookup_cnt, vecs[i].el);
            checkOutput($sformatf("v%0d mispred", i), mispred_cnt, vecs[i].em);
        end

        // Lookup counter wrap: preload near the top, then two lookups.
        @(negedge clk);
        applyStimulus(1, 32'h0, 0, 32'h0, 0, 0);
        dut.lookup_q = 32'hFFFF_FFFE;
        @(negedge clk);
        #1;
        checkOutput("wrap top", lookup_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 0);
        #1;
        checkOutput("wrap zero", lookup_cnt, 32'd0);

        // Async reset mid-stream: train 0x1000 to strongly taken first.
        @(negedge clk);
        applyStimulus(0, 32'h0, 1, 32'h1000, 1, 0);
        @(negedge clk);
        applyStimulus(0, 32'h0, 1, 32'h1000, 1, 1);
        @(negedge clk);
        applyStimulus(1, 32'h1000, 0, 32'h0, 0, 0);
        #1;
        checkOutput("pre-reset pred", {31'd0, pred_taken}, 32'd1);
        checkOutput("pre-reset mispred", mispred_cnt, 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset pred", {31'd0, pred_taken}, 32'd0);
        checkOutput("async reset lookup", lookup_cnt, 32'd0);
        checkOutput("async reset mispred", mispred_cnt, 32'd0);

        // An update presented while reset is held must be lost.
        applyStimulus(0, 32'h0, 1, 32'h1000, 1, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 32'h1000, 0, 32'h0, 0, 0);
        #1;
        checkOutput("post-reset pred", {31'd0, pred_taken}, 32'd0);
        checkOutput("post-reset mispred", mispred_cnt, 32'd0);

        // First edge after release behaves normally.
        @(negedge clk);
        applyStimulus(0, 32'h0, 1, 32'h1000, 1, 0);
        @(negedge clk);
        applyStimulus(1, 32'h1000, 0, 32'h0, 0, 0);
        #1;
        checkOutput("post-reset train pred", {31'd0, pred_taken}, 32'd1);
        checkOutput("post-reset lookup", lookup_cnt, 32'd1);

        @(negedge clk);
        applyStimulus(0, 32'h0, 0, 32'h0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Tagged, direct-mapped branch history table of 2-bit saturating counters. It supplies the taken/not-taken guess for a conditional branch in FD when its operands cannot be resolved there. It is trained with the true outcome once that branch resolves in X. It is the producer side of the `pred_taken` / mispredict exchange used by the core's control logic, and it also keeps wrapping performance counters for lookups and mispredictions.

## Interface
Parameters:
- `PC_WIDTH`, 32, width of PC inputs.
- `LINES`, 16, table entries; power of two, >= 2.
- `IDX_W`, derived as log2(`LINES`).
- `TAG_W`, derived as `PC_WIDTH` - `IDX_W` - 2.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc_guess`  in  `PC_WIDTH`  PC of the instruction currently in FD.
- `is_br_guess`  in  1  FD instruction is a branch needing a prediction.
- `pred_taken`  out  1  prediction for `pc_guess` (combinational).
- `pc_check`  in  `PC_WIDTH`  PC of the branch resolving in X.
- `is_br_check`  in  1  X holds a predicted branch whose outcome is valid this cycle.
- `br_taken_check`  in  1  actual outcome of that branch.
- `mispredict`  in  1  control logic flags a wrong guess for the X branch; sampled only when `is_br_check`=1.
- `lookup_cnt`  out  32  count of cycles with `is_br_guess`=1.
- `mispred_cnt`  out  32  count of cycles with `is_br_check`=1 and `mispredict`=1.

## Operation
- PC split: index = pc[`IDX_W`+1:2]; tag = pc[`PC_WIDTH`-1:`IDX_W`+2]; pc[1:0] ignored.
- Each entry holds `valid` (1 bit), `tag` (`TAG_W` bits) and `ctr` (2 bits). Counter encoding:
  - 00 strongly not-taken
  - 01 weakly not-taken
  - 10 weakly taken
  - 11 strongly taken
- Lookup (combinational):
  - Hit when entry[idx_guess].valid=1 and its tag equals tag_guess.
  - `pred_taken` = `is_br_guess` & hit & ctr[1].
  - A miss, or `is_br_guess`=0, gives 0.
- Update (rising edge, when `is_br_check`=1):
  - Hit on idx_check/tag_check: ctr increments if taken and decrements if not. It saturates at 11 and 00.
  - Miss (invalid entry or tag mismatch): the entry is allocated or overwritten with valid=1 and tag=tag_check. ctr=10 if taken, 01 if not taken.
  - `is_br_check`=0 leaves the table unchanged. `br_taken_check` and `mispredict` are then don't-care.
- Counters:
  - `lookup_cnt` += 1 per cycle with `is_br_guess`=1.
  - `mispred_cnt` += 1 per cycle with `is_br_check`&`mispredict`.
  - Both are 32-bit and wrap from FFFF_FFFF to 0.
- Simultaneous lookup and update to the same index: the lookup sees the pre-edge entry. There is no write-through bypass.

## Timing
- Prediction latency is 0 cycles. `pred_taken` is valid in the same cycle as `pc_guess` / `is_br_guess`, so it can feed FD PC selection.
- Update latency is 1 cycle. A lookup in the cycle after the update edge observes the new counter.
- Reset (`rst_n`=0, asynchronous assert):
  - All valid bits cleared; `lookup_cnt` and `mispred_cnt` = 0.
  - `pred_taken` reads 0 immediately.
  - Tag and ctr storage need no reset.
- Reset mid-operation: an update on the same edge as reset assertion is lost. The first edge with `rst_n`=1 behaves normally.
- Deassertion is expected synchronous to `clk`; the block does not resynchronize `rst_n`.
- No handshake or backpressure: every qualified cycle is consumed.

## Test plan
- Reset then lookup: `rst_n` low, release, `pc_guess`=0x0000_1000, `is_br_guess`=1 -> `pred_taken`=0, `lookup_cnt`=1 after the edge.
- Allocation and saturation (LINES=16):
  - Update pc 0x1000 taken -> next-cycle lookup of 0x1000 gives 1 (ctr 10).
  - Two more taken updates -> ctr stays 11.
  - Then one not-taken -> 1; second not-taken -> 0.
- Aliasing (same index, different tag): train 0x1000 taken twice (ctr 11), then update 0x1040 not-taken -> lookup 0x1040 gives 0 and lookup 0x1000 misses, giving 0.
- Same-cycle hazard: entry 0x2000 at ctr 01; lookup 0x2000 together with a taken update of 0x2000 -> `pred_taken`=0 that cycle, 1 the next cycle.
- Mispredict counting:
  - `mispredict`=1 with `is_br_check`=0 -> `mispred_cnt` unchanged.
  - `mispredict`=1 with `is_br_check`=1 for 3 cycles -> `mispred_cnt`=3.
  - Force `lookup_cnt` near FFFF_FFFF and issue 2 lookups -> wraps to 0.
- Async reset mid-stream: assert `rst_n` low between edges after training 0x1000 to 11 -> `pred_taken` drops to 0 before the next edge, and both counters read 0.
